// File: rtl/cam_sync_regen.sv
// Rebuilds hsync/vsync/de/x/y timing from a camera href/vsync pair.
// Vertical blanking lines are generated locally at the measured line period.
module cam_sync_regen #(
    parameter int H_ACT  = 1280,
    parameter int H_FP   = 220,
    parameter int H_SYNC = 100,
    parameter int V_ACT  = 720,
    parameter int V_FP   = 18,
    parameter int V_SYNC = 100,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1,
    parameter int CW     = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cam_href,
    input  logic          cam_vsync,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          locked,
    output logic          err
);

    typedef enum logic [2:0] {SEEK, WAIT, ACT, FP, SYNC, VBL} state_t;

    localparam logic [CW-1:0] LP_LMIN   = CW'(H_ACT + H_FP + H_SYNC);
    localparam logic [CW-1:0] LP_XLAST  = CW'(H_ACT - 1);
    localparam logic [CW-1:0] LP_FPLAST = CW'(H_FP - 1);
    localparam logic [CW-1:0] LP_HSLAST = CW'(H_SYNC - 1);
    localparam logic [CW-1:0] LP_HSYNC  = CW'(H_SYNC);
    localparam logic [CW-1:0] LP_VACT   = CW'(V_ACT);
    localparam logic [CW-1:0] LP_VSTART = CW'(V_ACT + V_FP);
    localparam logic [CW-1:0] LP_YLAST  = CW'(V_ACT + V_FP + V_SYNC - 1);

    state_t        r_state;
    logic          r_href, r_vs;
    logic [CW-1:0] r_x, r_y, r_cnt;
    logic [CW-1:0] r_hcnt, r_hper;
    logic          r_seen, r_hvld;
    logic          r_frame_ok, r_locked, r_err;

    logic          w_href_rise, w_href_fall, w_vs_rise;
    logic [CW-1:0] w_len, w_y_next;
    logic          w_hs_act, w_vs_act;

    assign w_href_rise = cam_href & ~r_href;
    assign w_href_fall = ~cam_href & r_href;
    assign w_vs_rise   = cam_vsync & ~r_vs;
    assign w_y_next    = r_y + 1'b1;
    // Lines shorter than the minimum (or not yet measured) are stretched to it.
    assign w_len       = (r_hvld && r_hper > LP_LMIN) ? r_hper : LP_LMIN;
    assign w_hs_act    = (r_state == SYNC) || (r_state == VBL && r_cnt >= w_len - LP_HSYNC);
    assign w_vs_act    = (r_state == VBL) && (r_y >= LP_VSTART);

    assign locked = r_locked;
    assign err    = r_err;

    // NOTE: all state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SEEK;
            r_href     <= 1'b0;
            r_vs       <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_cnt      <= '0;
            r_hcnt     <= '0;
            r_hper     <= '0;
            r_seen     <= 1'b0;
            r_hvld     <= 1'b0;
            r_frame_ok <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_href <= cam_href;
            r_vs   <= cam_vsync;
            r_err  <= 1'b0;

            if (w_href_rise) begin
                if (r_seen) begin
                    r_hper <= r_hcnt;
                    r_hvld <= 1'b1;
                end
                r_seen <= 1'b1;
                r_hcnt <= CW'(1);
            end else if (r_hcnt != '1) begin
                r_hcnt <= r_hcnt + 1'b1;
            end

            if (r_state == SEEK) begin
                if (w_vs_rise) begin
                    r_state    <= w_href_rise ? ACT : WAIT;
                    r_y        <= '0;
                    r_x        <= '0;
                    r_cnt      <= '0;
                    r_frame_ok <= 1'b1;
                end
            end else if (w_vs_rise) begin
                // A frame start resynchronises y; it is only legal at y=0 or in blanking.
                if (r_y != '0 && r_state != VBL) begin
                    r_err    <= 1'b1;
                    r_locked <= 1'b0;
                end
                r_state    <= w_href_rise ? ACT : WAIT;
                r_y        <= '0;
                r_x        <= '0;
                r_cnt      <= '0;
                r_frame_ok <= 1'b1;
            end else if (w_href_rise && r_state != WAIT) begin
                r_err      <= 1'b1;
                r_locked   <= 1'b0;
                r_frame_ok <= 1'b0;
                r_state    <= ACT;
                r_x        <= '0;
                r_cnt      <= '0;
                r_y        <= (r_state == VBL) ? '0 : w_y_next;
            end else begin
                case (r_state)
                    WAIT: begin
                        if (w_href_rise) begin
                            r_state <= ACT;
                            r_x     <= '0;
                        end
                    end
                    ACT: begin
                        if (w_href_fall && r_x < LP_XLAST) begin
                            r_err      <= 1'b1;
                            r_locked   <= 1'b0;
                            r_frame_ok <= 1'b0;
                        end
                        if (r_x == LP_XLAST) begin
                            r_state <= FP;
                            r_cnt   <= '0;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                    FP: begin
                        if (r_cnt == LP_FPLAST) begin
                            r_state <= SYNC;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    SYNC: begin
                        if (r_cnt == LP_HSLAST) begin
                            r_cnt   <= '0;
                            r_y     <= w_y_next;
                            r_state <= (w_y_next < LP_VACT) ? WAIT : VBL;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    VBL: begin
                        if (r_cnt == w_len - 1'b1) begin
                            r_cnt <= '0;
                            if (r_y >= LP_YLAST) begin
                                r_state    <= WAIT;
                                r_y        <= '0;
                                r_locked   <= r_frame_ok;
                                r_frame_ok <= 1'b1;
                            end else begin
                                r_y <= w_y_next;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= SEEK;
                endcase
            end
        end
    end

    // Output stage: registered copies of the FSM view, two cycles behind href_rise.
    always_ff @(posedge clk) begin
        if (rst) begin
            de    <= 1'b0;
            x     <= '0;
            y     <= '0;
            hsync <= ~HS_POL;
            vsync <= ~VS_POL;
        end else begin
            de    <= (r_state == ACT);
            x     <= (r_state == ACT) ? r_x : '0;
            y     <= r_y;
            hsync <= w_hs_act ? HS_POL : ~HS_POL;
            vsync <= w_vs_act ? VS_POL : ~VS_POL;
        end
    end

endmodule
